// File: rtl/adc_frame_capture.sv
// adc_frame_capture: frames paired ADC samples on a chirp sync, packs each pair
// into a 32-bit word and streams it out through a show-ahead FIFO.
module adc_frame_capture #(
  parameter int unsigned bit_width  = 14,
  parameter int unsigned frame_len  = 256,
  parameter int unsigned fifo_depth = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 sync_in,
  input  logic                 sample_valid_in,
  input  logic [bit_width-1:0] data_a_in,
  input  logic [bit_width-1:0] data_b_in,
  input  logic                 overrange_a_in,
  input  logic                 overrange_b_in,
  output logic [31:0]          m_data_out,
  output logic                 m_valid_out,
  input  logic                 m_ready_in,
  output logic                 m_last_out,
  output logic                 busy_out,
  output logic                 frame_ovr_out,
  output logic [15:0]          drop_cnt_out,
  output logic                 sync_err_out,
  output logic                 done_out
);

  localparam int unsigned addr_w = $clog2(fifo_depth);
  localparam int unsigned cnt_w  = 16;
  localparam int unsigned word_w = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  typedef struct packed {
    logic              last;
    logic [word_w-1:0] data;
  } entry_t;

  state_t            state_q;
  state_t            state_d;
  logic [addr_w:0]   wr_ptr_q;
  logic [addr_w:0]   rd_ptr_q;
  entry_t            mem_q [fifo_depth];
  entry_t            head_c;
  logic [cnt_w-1:0]  sample_cnt_q;
  logic [cnt_w-1:0]  drop_cnt_q;
  logic              frame_ovr_q;
  logic              sync_err_q;
  logic              done_q;
  logic              busy_q;

  logic              fifo_empty_c;
  logic              fifo_full_c;
  logic              pop_c;
  logic              push_try_c;
  logic              push_ok_c;
  logic              last_push_c;
  logic              frame_start_c;
  logic [word_w-1:0] packed_word_c;

  // FIFO status, handshake and push qualification
  always_comb begin
    fifo_empty_c  = (wr_ptr_q == rd_ptr_q);
    fifo_full_c   = (wr_ptr_q[addr_w] != rd_ptr_q[addr_w]) &&
                    (wr_ptr_q[addr_w-1:0] == rd_ptr_q[addr_w-1:0]);
    head_c        = mem_q[rd_ptr_q[addr_w-1:0]];
    pop_c         = !fifo_empty_c && m_ready_in;
    push_try_c    = (state_q == CAPTURE) && sample_valid_in;
    push_ok_c     = push_try_c && (!fifo_full_c || pop_c);
    last_push_c   = (sample_cnt_q == cnt_w'(frame_len - 1));
    frame_start_c = (state_q == IDLE) && sync_in;
  end

  // Pack overrange flags and both channel samples into one word
  always_comb begin
    packed_word_c                  = '0;
    packed_word_c[31]              = overrange_a_in;
    packed_word_c[30]              = overrange_b_in;
    packed_word_c[16 +: bit_width] = data_a_in;
    packed_word_c[0 +: bit_width]  = data_b_in;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sync_in) state_d = CAPTURE;
      CAPTURE: if (push_ok_c && last_push_c) state_d = DRAIN;
      DRAIN:   if (pop_c && head_c.last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // FIFO pointers; reset empties the FIFO and discards pending words
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + (addr_w + 1)'(1);
      if (pop_c)     rd_ptr_q <= rd_ptr_q + (addr_w + 1)'(1);
    end
  end

  // FIFO storage, tagged with the end-of-frame marker
  always_ff @(posedge clk_in) begin
    if (push_ok_c) mem_q[wr_ptr_q[addr_w-1:0]] <= '{last: last_push_c, data: packed_word_c};
  end

  // Frame counters and sticky status, cleared on an accepted sync
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sample_cnt_q <= '0;
      drop_cnt_q   <= '0;
      frame_ovr_q  <= 1'b0;
    end else if (frame_start_c) begin
      sample_cnt_q <= '0;
      drop_cnt_q   <= '0;
      frame_ovr_q  <= 1'b0;
    end else if (push_ok_c) begin
      sample_cnt_q <= sample_cnt_q + cnt_w'(1);
      frame_ovr_q  <= frame_ovr_q | overrange_a_in | overrange_b_in;
    end else if (push_try_c && (drop_cnt_q != {cnt_w{1'b1}})) begin
      drop_cnt_q   <= drop_cnt_q + cnt_w'(1);
    end
  end

  // Registered pulses and busy flag
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_err_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync_err_q <= sync_in && (state_q != IDLE);
      done_q     <= (state_q == DRAIN) && pop_c && head_c.last;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign m_valid_out   = !fifo_empty_c;
  assign m_data_out    = fifo_empty_c ? '0 : head_c.data;
  assign m_last_out    = !fifo_empty_c && head_c.last;
  assign busy_out      = busy_q;
  assign frame_ovr_out = frame_ovr_q;
  assign drop_cnt_out  = drop_cnt_q;
  assign sync_err_out  = sync_err_q;
  assign done_out      = done_q;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Bench for adc_frame_capture: per-cycle vector table plus a reset-mid-frame sequence.
module tb_adc_frame_capture;

  localparam int unsigned bw = 14;

  logic          clk_in;
  logic          rst_n_in;
  logic          sync_in;
  logic          sample_valid_in;
  logic [bw-1:0] data_a_in;
  logic [bw-1:0] data_b_in;
  logic          overrange_a_in;
  logic          overrange_b_in;
  logic [31:0]   m_data_out;
  logic          m_valid_out;
  logic          m_ready_in;
  logic          m_last_out;
  logic          busy_out;
  logic          frame_ovr_out;
  logic [15:0]   drop_cnt_out;
  logic          sync_err_out;
  logic          done_out;

  int checks;
  int failures;

  adc_frame_capture #(
    .bit_width (14),
    .frame_len (8),
    .fifo_depth(4)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .sync_in        (sync_in),
    .sample_valid_in(sample_valid_in),
    .data_a_in      (data_a_in),
    .data_b_in      (data_b_in),
    .overrange_a_in (overrange_a_in),
    .overrange_b_in (overrange_b_in),
    .m_data_out     (m_data_out),
    .m_valid_out    (m_valid_out),
    .m_ready_in     (m_ready_in),
    .m_last_out     (m_last_out),
    .busy_out       (busy_out),
    .frame_ovr_out  (frame_ovr_out),
    .drop_cnt_out   (drop_cnt_out),
    .sync_err_out   (sync_err_out),
    .done_out       (done_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        done;
    logic        busy;
    logic        ovr;
    logic [15:0] drop;
    logic        err;
  } outs_t;

  typedef struct packed {
    logic          sync;
    logic          valid;
    logic [bw-1:0] a;
    logic [bw-1:0] b;
    logic          ova;
    logic          ovb;
    logic          ready;
    outs_t         exp;
  } vec_t;

  localparam int n_vec = 28;
  vec_t tbl [n_vec];

  function automatic outs_t mk_out(input logic ev, input logic [31:0] ed, input logic el,
                                   input logic edn, input logic eb, input logic eo,
                                   input logic [15:0] edr, input logic ee);
    outs_t o;
    o = {ev, ed, el, edn, eb, eo, edr, ee};
    return o;
  endfunction

  function automatic vec_t mk(input logic s, input logic v, input logic [bw-1:0] a,
                              input logic [bw-1:0] b, input logic oa, input logic r,
                              input outs_t e);
    vec_t t;
    t.sync = s; t.valid = v; t.a = a; t.b = b;
    t.ova = oa; t.ovb = 1'b0; t.ready = r; t.exp = e;
    return t;
  endfunction

  task automatic check(input outs_t e, input string tag);
    outs_t act;
    act = {m_valid_out, m_data_out, m_last_out, done_out, busy_out,
           frame_ovr_out, drop_cnt_out, sync_err_out};
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got v=%0b d=%08h l=%0b dn=%0b b=%0b o=%0b dr=%0d e=%0b want v=%0b d=%08h l=%0b dn=%0b b=%0b o=%0b dr=%0d e=%0b",
               tag, act.valid, act.data, act.last, act.done, act.busy, act.ovr, act.drop, act.err,
               e.valid, e.data, e.last, e.done, e.busy, e.ovr, e.drop, e.err);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic [bw-1:0] a,
                       input logic [bw-1:0] b, input logic oa, input logic ob,
                       input logic r);
    sync_in = s; sample_valid_in = v; data_a_in = a; data_b_in = b;
    overrange_a_in = oa; overrange_b_in = ob; m_ready_in = r;
  endtask

  task automatic apply(input vec_t t, input string tag);
    drive(t.sync, t.valid, t.a, t.b, t.ova, t.ovb, t.ready);
    @(posedge clk_in);
    #1;
    check(t.exp, tag);
  endtask

  initial begin
    logic [31:0] w;
    logic [bw-1:0] a;
    logic [bw-1:0] b;
    logic ob;
    checks = 0;
    failures = 0;
    rst_n_in = 1'b0;
    drive(0, 0, '0, '0, 0, 0, 0);

    // Frame 1: full throughput, overrange on sample 2, stray sync on sample 5
    tbl[0]  = mk(1, 0, 0,  0,   0, 1, mk_out(0, 32'h0,        0, 0, 1, 0, 0, 0));
    tbl[1]  = mk(0, 1, 1,  100, 0, 1, mk_out(1, 32'h00010064, 0, 0, 1, 0, 0, 0));
    tbl[2]  = mk(0, 1, 2,  101, 1, 1, mk_out(1, 32'h80020065, 0, 0, 1, 1, 0, 0));
    tbl[3]  = mk(0, 1, 3,  102, 0, 1, mk_out(1, 32'h00030066, 0, 0, 1, 1, 0, 0));
    tbl[4]  = mk(0, 1, 4,  103, 0, 1, mk_out(1, 32'h00040067, 0, 0, 1, 1, 0, 0));
    tbl[5]  = mk(1, 1, 5,  104, 0, 1, mk_out(1, 32'h00050068, 0, 0, 1, 1, 0, 1));
    tbl[6]  = mk(0, 1, 6,  105, 0, 1, mk_out(1, 32'h00060069, 0, 0, 1, 1, 0, 0));
    tbl[7]  = mk(0, 1, 7,  106, 0, 1, mk_out(1, 32'h0007006A, 0, 0, 1, 1, 0, 0));
    tbl[8]  = mk(0, 1, 8,  107, 0, 1, mk_out(1, 32'h0008006B, 1, 0, 1, 1, 0, 0));
    tbl[9]  = mk(0, 0, 0,  0,   0, 1, mk_out(0, 32'h0,        0, 1, 0, 1, 0, 0));
    tbl[10] = mk(0, 0, 0,  0,   0, 1, mk_out(0, 32'h0,        0, 0, 0, 1, 0, 0));
    // Frame 2: backpressure fills the FIFO, samples 5 and 6 drop
    tbl[11] = mk(1, 0, 0,  0,   0, 0, mk_out(0, 32'h0,        0, 0, 1, 0, 0, 0));
    tbl[12] = mk(0, 1, 11, 21,  0, 0, mk_out(1, 32'h000B0015, 0, 0, 1, 0, 0, 0));
    tbl[13] = mk(0, 1, 12, 22,  0, 0, mk_out(1, 32'h000B0015, 0, 0, 1, 0, 0, 0));
    tbl[14] = mk(0, 1, 13, 23,  0, 0, mk_out(1, 32'h000B0015, 0, 0, 1, 0, 0, 0));
    tbl[15] = mk(0, 1, 14, 24,  0, 0, mk_out(1, 32'h000B0015, 0, 0, 1, 0, 0, 0));
    tbl[16] = mk(0, 1, 15, 25,  0, 0, mk_out(1, 32'h000B0015, 0, 0, 1, 0, 1, 0));
    tbl[17] = mk(0, 1, 16, 26,  0, 0, mk_out(1, 32'h000B0015, 0, 0, 1, 0, 2, 0));
    // Full FIFO with simultaneous pop: pushes accepted, drop count unchanged
    tbl[18] = mk(0, 1, 17, 27,  0, 1, mk_out(1, 32'h000C0016, 0, 0, 1, 0, 2, 0));
    tbl[19] = mk(0, 1, 18, 28,  0, 1, mk_out(1, 32'h000D0017, 0, 0, 1, 0, 2, 0));
    tbl[20] = mk(0, 1, 19, 29,  0, 1, mk_out(1, 32'h000E0018, 0, 0, 1, 0, 2, 0));
    tbl[21] = mk(0, 1, 20, 30,  0, 1, mk_out(1, 32'h0011001B, 0, 0, 1, 0, 2, 0));
    tbl[22] = mk(0, 1, 21, 31,  0, 1, mk_out(1, 32'h0012001C, 0, 0, 1, 0, 2, 0));
    tbl[23] = mk(0, 0, 0,  0,   0, 1, mk_out(1, 32'h0013001D, 0, 0, 1, 0, 2, 0));
    tbl[24] = mk(0, 0, 0,  0,   0, 1, mk_out(1, 32'h0014001E, 1, 0, 1, 0, 2, 0));
    tbl[25] = mk(0, 0, 0,  0,   0, 1, mk_out(0, 32'h0,        0, 1, 0, 0, 2, 0));
    // Sync coincident with a sample in IDLE: sample ignored
    tbl[26] = mk(1, 1, 63, 63,  1, 1, mk_out(0, 32'h0,        0, 0, 1, 0, 0, 0));
    tbl[27] = mk(0, 0, 0,  0,   0, 1, mk_out(0, 32'h0,        0, 0, 1, 0, 0, 0));

    #12;
    check('0, "reset_state");
    rst_n_in = 1'b1;

    for (int i = 0; i < n_vec; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset mid-frame with two words pending
    drive(0, 1, 14'h21, 14'h31, 0, 0, 0);
    @(posedge clk_in); #1;
    check(mk_out(1, 32'h00210031, 0, 0, 1, 0, 0, 0), "rst_pre1");
    drive(0, 1, 14'h22, 14'h32, 0, 0, 0);
    @(posedge clk_in); #1;
    check(mk_out(1, 32'h00210031, 0, 0, 1, 0, 0, 0), "rst_pre2");
    rst_n_in = 1'b0;
    #1;
    check('0, "rst_async");
    drive(0, 0, '0, '0, 0, 0, 1);
    @(posedge clk_in); #1;
    check('0, "rst_held");
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    check('0, "rst_no_done");

    // Clean frame after reset; last sample hits full-scale on both channels
    drive(1, 0, '0, '0, 0, 0, 1);
    @(posedge clk_in); #1;
    check(mk_out(0, 32'h0, 0, 0, 1, 0, 0, 0), "post_sync");
    for (int k = 1; k <= 8; k++) begin
      a  = (k == 8) ? 14'h3FFF : bw'(32'h40 + k);
      b  = (k == 8) ? 14'h3FFF : bw'(k);
      ob = (k == 8);
      w  = (k == 8) ? 32'h7FFF3FFF : ((32'h40 + 32'(k)) << 16) | 32'(k);
      drive(0, 1, a, b, 0, ob, 1);
      @(posedge clk_in); #1;
      check(mk_out(1, w, k == 8, 0, 1, k == 8, 0, 0), $sformatf("post_word%0d", k));
    end
    drive(0, 0, '0, '0, 0, 0, 1);
    @(posedge clk_in); #1;
    check(mk_out(0, 32'h0, 0, 1, 0, 1, 0, 0), "post_done");
    @(posedge clk_in); #1;
    check(mk_out(0, 32'h0, 0, 0, 0, 1, 0, 0), "post_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
